// File: rtl/ser2_tx.sv
// ser2_tx: two-lane parallel-to-serial transmitter feeding an ofd2 output-register pair.
module ser2_tx #(
  parameter int   WIDTH    = 16,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             CK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VLD,
  output logic             IN_RDY,
  output logic             S1,
  output logic             S0,
  output logic             FRM,
  output logic             SOF
);
  localparam int CW = $clog2(WIDTH / 2);
  localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [WIDTH-3:0] sr, sr_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic s1_nx, s0_nx, frm_nx, sof_nx, accept;
  // ready also covers the last pair of a word so frames chain with no gap
  assign IN_RDY = RST_N && CE && (state == IDLE || cnt == '0);
  assign accept = IN_VLD && IN_RDY;
  always_ff @(posedge CK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      S1    <= IDLE_LVL;
      S0    <= IDLE_LVL;
      FRM   <= 1'b0;
      SOF   <= 1'b0;
    end else begin
      state <= state_nx;
      sr    <= sr_nx;
      cnt   <= cnt_nx;
      S1    <= s1_nx;
      S0    <= s0_nx;
      FRM   <= frm_nx;
      SOF   <= sof_nx;
    end
  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    cnt_nx   = cnt;
    s1_nx    = S1;
    s0_nx    = S0;
    frm_nx   = FRM;
    sof_nx   = SOF;
    if (accept) begin
      state_nx = SHIFT;
      s1_nx    = IN_DATA[WIDTH-1];
      s0_nx    = IN_DATA[WIDTH-2];
      sr_nx    = IN_DATA[WIDTH-3:0];
      cnt_nx   = LAST;
      frm_nx   = 1'b1;
      sof_nx   = 1'b1;
    end else if (CE && state == SHIFT) begin
      if (cnt != '0) begin
        s1_nx  = sr[WIDTH-3];
        s0_nx  = sr[WIDTH-4];
        sr_nx  = sr << 2;
        cnt_nx = cnt - 1'b1;
        sof_nx = 1'b0;
      end else begin
        state_nx = IDLE;
        s1_nx    = IDLE_LVL;
        s0_nx    = IDLE_LVL;
        frm_nx   = 1'b0;
        sof_nx   = 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ser2_tx.sv
// tb_ser2_tx: vector table, hand sequences and randomized model check for ser2_tx.
module tb_ser2_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;
  logic ce = 1'b0, vld = 1'b0;
  logic [7:0] d = '0;
  logic rdy, s1, s0, frm, sof;
  logic ce4 = 1'b0, vld4 = 1'b0;
  logic [3:0] d4 = '0;
  logic rdy4, s14, s04, frm4, sof4;
  int checks = 0, failures = 0;

  ser2_tx #(.WIDTH(8), .IDLE_LVL(1'b0)) dut (
    .CK(clk), .RST_N(rst_n), .CE(ce), .IN_DATA(d), .IN_VLD(vld),
    .IN_RDY(rdy), .S1(s1), .S0(s0), .FRM(frm), .SOF(sof));

  ser2_tx #(.WIDTH(4), .IDLE_LVL(1'b1)) dut4 (
    .CK(clk), .RST_N(rst_n), .CE(ce4), .IN_DATA(d4), .IN_VLD(vld4),
    .IN_RDY(rdy4), .S1(s14), .S0(s04), .FRM(frm4), .SOF(sof4));

  typedef struct {
    logic ce, vld;
    logic [7:0] d;
    logic rdy, s1, s0, frm, sof;
  } vec_t;
  vec_t tv[28];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic e1, e0, ef, es);
    chk({name, "_s1"}, s1, e1);
    chk({name, "_s0"}, s0, e0);
    chk({name, "_frm"}, frm, ef);
    chk({name, "_sof"}, sof, es);
  endtask

  task automatic cyc(input logic c, v, input logic [7:0] dd, output logic r);
    @(negedge clk);
    ce = c; vld = v; d = dd;
    #1 r = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc4(input logic c, v, input logic [3:0] dd, output logic r);
    @(negedge clk);
    ce4 = c; vld4 = v; d4 = dd;
    #1 r = rdy4;
    @(posedge clk);
    #1;
  endtask

  logic r;
  logic [7:0] m_word;
  int m_p;
  logic m_act, c, v, e_rdy;
  logic [7:0] dd;

  initial begin
    // single word 0xB4
    tv[0]  = '{1, 1, 8'hB4, 1, 1, 0, 1, 1};
    tv[1]  = '{1, 0, 8'h00, 0, 1, 1, 1, 0};
    tv[2]  = '{1, 0, 8'h00, 0, 0, 1, 1, 0};
    tv[3]  = '{1, 0, 8'h00, 0, 0, 0, 1, 0};
    tv[4]  = '{1, 0, 8'h00, 1, 0, 0, 0, 0};
    // back-to-back 0xFF then 0x00
    tv[5]  = '{1, 1, 8'hFF, 1, 1, 1, 1, 1};
    tv[6]  = '{1, 1, 8'h00, 0, 1, 1, 1, 0};
    tv[7]  = '{1, 1, 8'h00, 0, 1, 1, 1, 0};
    tv[8]  = '{1, 1, 8'h00, 0, 1, 1, 1, 0};
    tv[9]  = '{1, 1, 8'h00, 1, 0, 0, 1, 1};
    tv[10] = '{1, 0, 8'h00, 0, 0, 0, 1, 0};
    tv[11] = '{1, 0, 8'h00, 0, 0, 0, 1, 0};
    tv[12] = '{1, 0, 8'h00, 0, 0, 0, 1, 0};
    tv[13] = '{1, 0, 8'h00, 1, 0, 0, 0, 0};
    // CE stall
    tv[14] = '{1, 1, 8'hB4, 1, 1, 0, 1, 1};
    tv[15] = '{0, 0, 8'h00, 0, 1, 0, 1, 1};
    tv[16] = '{1, 0, 8'h00, 0, 1, 1, 1, 0};
    tv[17] = '{0, 0, 8'h00, 0, 1, 1, 1, 0};
    tv[18] = '{1, 0, 8'h00, 0, 0, 1, 1, 0};
    tv[19] = '{0, 0, 8'h00, 0, 0, 1, 1, 0};
    tv[20] = '{1, 0, 8'h00, 0, 0, 0, 1, 0};
    tv[21] = '{0, 1, 8'h55, 0, 0, 0, 1, 0};
    tv[22] = '{1, 0, 8'h00, 1, 0, 0, 0, 0};
    // busy ignore
    tv[23] = '{1, 1, 8'hB4, 1, 1, 0, 1, 1};
    tv[24] = '{1, 1, 8'h55, 0, 1, 1, 1, 0};
    tv[25] = '{1, 1, 8'h55, 0, 0, 1, 1, 0};
    tv[26] = '{1, 0, 8'h00, 0, 0, 0, 1, 0};
    tv[27] = '{1, 0, 8'h00, 1, 0, 0, 0, 0};

    #2 rst_n = 1'b0;
    #1;
    chk_out("reset", 0, 0, 0, 0);
    chk("reset_s1_w4", s14, 1);
    chk("reset_s0_w4", s04, 1);
    chk("reset_frm_w4", frm4, 0);
    ce = 1'b1;
    #1 chk("reset_rdy", rdy, 0);
    ce = 1'b0;
    #20 rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      cyc(tv[i].ce, tv[i].vld, tv[i].d, r);
      chk($sformatf("tv%0d_rdy", i), r, tv[i].rdy);
      chk_out($sformatf("tv%0d", i), tv[i].s1, tv[i].s0, tv[i].frm, tv[i].sof);
    end

    // mid-frame reset during pair 3 of 0xB4
    cyc(1, 1, 8'hB4, r);
    cyc(1, 0, 8'h00, r);
    cyc(1, 0, 8'h00, r);
    chk_out("pre_rst", 0, 1, 1, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 0, 0, 0, 0);
    chk("mid_rst_rdy", rdy, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk_out("post_rst", 0, 0, 0, 0);
    cyc(1, 1, 8'h0F, r);
    chk("x0f_rdy", r, 1);
    chk_out("x0f_p1", 0, 0, 1, 1);
    cyc(1, 0, 8'h00, r);
    chk_out("x0f_p2", 0, 0, 1, 0);
    cyc(1, 0, 8'h00, r);
    chk_out("x0f_p3", 1, 1, 1, 0);
    cyc(1, 0, 8'h00, r);
    chk_out("x0f_p4", 1, 1, 1, 0);
    cyc(1, 0, 8'h00, r);
    chk_out("x0f_end", 0, 0, 0, 0);

    // idle level 1, WIDTH 4, word 0x6
    cyc4(1, 0, 4'h0, r);
    chk("w4_idle_s1", s14, 1);
    chk("w4_idle_s0", s04, 1);
    cyc4(1, 1, 4'h6, r);
    chk("w4_rdy", r, 1);
    chk("w4_p1", {s14, s04, frm4, sof4}, 4'b0111);
    cyc4(1, 0, 4'h0, r);
    chk("w4_p2", {s14, s04, frm4, sof4}, 4'b1010);
    cyc4(1, 0, 4'h0, r);
    chk("w4_rdy_last", r, 1);
    chk("w4_end", {s14, s04, frm4, sof4}, 4'b1100);

    // randomized run against a pair-index reference model
    m_act = 1'b0; m_p = 0; m_word = '0;
    for (int n = 0; n < 3000; n++) begin
      c = $urandom_range(0, 3) != 0;
      v = $urandom_range(0, 2) != 0;
      dd = 8'($urandom);
      e_rdy = c && (!m_act || m_p == 3);
      cyc(c, v, dd, r);
      chk("rnd_rdy", r, e_rdy);
      if (c) begin
        if (v && e_rdy) begin
          m_word = dd; m_p = 0; m_act = 1'b1;
        end else if (m_act) begin
          if (m_p == 3) m_act = 1'b0;
          else m_p++;
        end
      end
      chk_out("rnd", m_act ? m_word[7 - 2 * m_p] : 1'b0, m_act ? m_word[6 - 2 * m_p] : 1'b0,
              m_act, m_act && m_p == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ser2_tx.md
# ser2_tx

Two-lane parallel-to-serial transmitter that sits directly upstream of the `ofd2` output-register pair. It accepts a WIDTH-bit word over a valid/ready handshake and drives it out two bits per clock-enable cycle on `S1`/`S0`, MSB pair first. `S1`/`S0` connect to `ofd2` `D1`/`D0`, so pad data lags these outputs by one further `CK` edge. Back-to-back words stream with no idle gap.

## Interface
Parameters:
- `WIDTH`, 16, word width in bits; must be even and ≥ 4.
- `IDLE_LVL`, 1'b0, level driven on `S0`/`S1` when no frame is active.

Ports:
- `CK`, input, 1, single clock; all state is updated on the rising edge.
- `RST_N`, input, 1, asynchronous active-low reset.
- `CE`, input, 1, clock enable. Loads and shifts occur only on edges where `CE`=1.
- `IN_DATA`, input, WIDTH, word to transmit.
- `IN_VLD`, input, 1, `IN_DATA` is valid.
- `IN_RDY`, output, 1, block accepts a word on this edge.
- `S1`, output, 1, odd bit of the current pair (to `ofd2` `D1`).
- `S0`, output, 1, even bit of the current pair (to `ofd2` `D0`).
- `FRM`, output, 1, high while a pair belonging to a word is on `S1`/`S0`.
- `SOF`, output, 1, high for the first pair of each word.

Decided: one clock; reset is asynchronous and active-low (`CK`, `RST_N`).

## Operation
- **State:** `IDLE` or `SHIFT`. The registers are:
  - shift register `SR` (WIDTH-2 bits);
  - pair counter `CNT` (⌈log2(WIDTH/2)⌉ bits), holding the number of pairs still to follow the displayed pair;
  - the output registers `S1`, `S0`, `FRM`, `SOF`.
- **Reset (async, `RST_N`=0):**
  - state = `IDLE`, `CNT` = 0, `SR` = 0;
  - `S1` = `S0` = `IDLE_LVL`, `FRM` = 0, `SOF` = 0.
- **`IN_RDY`:** combinational, equal to `CE && (state==IDLE || CNT==0)`. It is 0 while `RST_N`=0. The word transfers on an edge where `IN_VLD && IN_RDY`.
- **Accept (from either state):**
  - `S1` ← `IN_DATA[W-1]`, `S0` ← `IN_DATA[W-2]`;
  - `SR` ← `IN_DATA[W-3:0]`, `CNT` ← W/2-1;
  - `FRM` ← 1, `SOF` ← 1, state ← `SHIFT`.
- **`SHIFT`, `CE`=1, `CNT`≠0:**
  - `S1` ← `SR[W-3]`, `S0` ← `SR[W-4]`;
  - `SR` ← `SR` << 2 (zero fill), `CNT` ← `CNT`-1, `SOF` ← 0.
- **`SHIFT`, `CE`=1, `CNT`=0, no accept:** state ← `IDLE`; `S1`/`S0` ← `IDLE_LVL`; `FRM` ← 0; `SOF` ← 0.
- **`SHIFT`, `CE`=1, `CNT`=0, accept:** apply the accept rule. The new word's first pair directly follows the old word's last pair.
- **`CE`=0:** every register holds, including `SOF`. `IN_RDY`=0.
- **`IDLE`, `CE`=1, no `IN_VLD`:** outputs stay at idle values.
- **Hold rule:** `IN_DATA` is sampled only on the accept edge. Changes on `IN_DATA` at other times have no effect.

## Timing
- **Latency:** the first pair of a word appears on `S1`/`S0` one `CK` after the accept edge, and on the `ofd2` pads one `CK` later.
- **Frame length:** exactly W/2 `CE`-qualified cycles of `FRM`=1 per word. `SOF` is high for the first of these only (it stays high across `CE`=0 stall cycles).
- **Throughput:** one word per W/2 `CE` cycles when `IN_VLD` is held high. `FRM` has no gap between words, and `SOF` pulses at the start of each word.
- **Mid-frame reset:** `RST_N` falling at any point forces the reset values immediately, with no clock edge needed. The frame in progress is discarded, and after release the block is in `IDLE`.
- **Reset release:** release is asynchronous to `CK`. The first accept can occur on the first `CK` edge after release with `CE`=1.

## Test plan
- **Single word.** Stimulus: WIDTH=8, `IDLE_LVL`=0, `CE`=1, `IN_DATA`=0xB4, one-cycle `IN_VLD`. Required response:
  - (`S1`,`S0`) = (1,0), (1,1), (0,1), (0,0) on the 4 cycles after accept;
  - `FRM`=1 for those 4 cycles, `SOF`=1 on the first only;
  - then (0,0) with `FRM`=0.
- **Back-to-back words.** Stimulus: `IN_DATA`=0xFF then 0x00 with `IN_VLD` held high. Required response:
  - `IN_RDY` is high on the accept cycle and on the cycle showing the 4th pair of 0xFF;
  - `S1`/`S0` = (1,1)×4 then (0,0)×4;
  - `FRM` is continuously 1 for 8 cycles, with `SOF` pulses at cycles 1 and 5.
- **CE stall.** Stimulus: 0xB4 with `CE` toggling 1,0,1,0… Required response:
  - each pair is held 2 `CK` cycles; the pair sequence is identical to the single-word case;
  - `IN_RDY` is never high while `CE`=0.
- **Busy ignore.** Stimulus: `IN_VLD`=1 with `IN_DATA`=0x55 asserted during pair 2 of 0xB4. Required response:
  - `IN_RDY`=0 there, so 0x55 is not taken;
  - 0xB4 completes unchanged.
- **Mid-frame reset.** Stimulus: assert `RST_N`=0 during pair 3. Required response:
  - outputs immediately become `IDLE_LVL`, `FRM`=0, `SOF`=0;
  - after release, 0x0F sent alone gives (0,0), (0,0), (1,1), (1,1).
- **Idle level.** Stimulus: `IDLE_LVL`=1, WIDTH=4, `IN_DATA`=0x6. Required response:
  - idle (1,1);
  - then (0,1), (1,0);
  - then back to (1,1).
